// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

   localparam int unsigned MEM_ADDR_W_DEF = 18;
   localparam int unsigned DATA_W_DEF     = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } state_e;

   // Request fields still needed after the accept cycle
   typedef struct packed {
      logic       write;
      size_e      size;
      logic       is_unsigned;
      logic [7:0] wdata_hi;
   } lsu_req_t;

endpackage

// File: rtl/lsu_load_align.sv
// Assembles byte/half/word load data and applies sign or zero extension.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
)(
   input  size_e             size,
   input  logic              is_unsigned,
   input  logic [7:0]        lo_byte,
   input  logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] load_data_c
);

   logic [7:0]  b;
   logic [15:0] h;

   // Halfword high byte arrives on the second access; low byte was captured earlier
   always_comb begin
      b = read_data[7:0];
      h = {read_data[7:0], lo_byte};
      case (size)
         SZ_BYTE: load_data_c = {{(DATA_W-8){b[7] & ~is_unsigned}}, b};
         SZ_HALF: load_data_c = {{(DATA_W-16){h[15] & ~is_unsigned}}, h};
         default: load_data_c = read_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-side initiator: sequences byte/word memory strobes for one request at a time,
// splitting halfwords into two byte accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_error,
   output logic                  memRead,
   output logic                  memWrite,
   output logic                  byteOperations,
   output logic [MEM_ADDR_W-1:0] address,
   output logic [DATA_W-1:0]     write_data,
   input  logic [DATA_W-1:0]     read_data
);

   state_e                state, state_n;
   lsu_req_t              req_q, req_n;
   logic [7:0]            lo_q, lo_n;
   logic                  ready_n, valid_n, error_n, rd_n, wr_n, bo_n;
   logic [DATA_W-1:0]     rdata_n, wdata_n;
   logic [MEM_ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0]     load_data_c;
   logic                  req_err_c;

   lsu_load_align #(.DATA_W(DATA_W)) u_align (
      .size        (req_q.size),
      .is_unsigned (req_q.is_unsigned),
      .lo_byte     (lo_q),
      .read_data   (read_data),
      .load_data_c (load_data_c)
   );

   assign req_err_c = ((req_addr >> MEM_ADDR_W) != 32'd0)
                    || (req_size == SZ_ILL)
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || ((req_size == SZ_HALF) && req_addr[0]);

   always_comb begin
      state_n = state;
      req_n   = req_q;
      lo_n    = lo_q;
      rdata_n = resp_rdata;
      error_n = resp_error;
      rd_n    = 1'b0;
      wr_n    = 1'b0;
      bo_n    = byteOperations;
      addr_n  = address;
      wdata_n = write_data;
      case (state)
         IDLE: begin
            if (req_valid) begin
               req_n = '{write: req_write, size: size_e'(req_size),
                         is_unsigned: req_unsigned, wdata_hi: req_wdata[15:8]};
               rdata_n = '0;
               error_n = req_err_c;
               if (req_err_c) begin
                  state_n = RESP;
               end else begin
                  state_n = ACC0;
                  rd_n    = ~req_write;
                  wr_n    = req_write;
                  bo_n    = (req_size != SZ_WORD);
                  // Word mode addresses the memory by word index
                  if (req_size == SZ_WORD) begin
                     addr_n  = {2'b00, req_addr[MEM_ADDR_W-1:2]};
                     wdata_n = req_wdata;
                  end else begin
                     addr_n  = req_addr[MEM_ADDR_W-1:0];
                     wdata_n = DATA_W'(req_wdata[7:0]);
                  end
               end
            end
         end
         ACC0: begin
            if (req_q.size == SZ_HALF) begin
               state_n = ACC1;
               lo_n    = read_data[7:0];
               rd_n    = ~req_q.write;
               wr_n    = req_q.write;
               addr_n  = address + MEM_ADDR_W'(1);
               wdata_n = DATA_W'(req_q.wdata_hi);
            end else begin
               state_n = RESP;
               rdata_n = req_q.write ? '0 : load_data_c;
            end
         end
         ACC1: begin
            state_n = RESP;
            rdata_n = req_q.write ? '0 : load_data_c;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      ready_n = (state_n == IDLE);
      valid_n = (state_n == RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         req_q          <= '0;
         lo_q           <= '0;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         resp_error     <= 1'b0;
         memRead        <= 1'b0;
         memWrite       <= 1'b0;
         byteOperations <= 1'b0;
         address        <= '0;
         write_data     <= '0;
      end else begin
         state          <= state_n;
         req_q          <= req_n;
         lo_q           <= lo_n;
         req_ready      <= ready_n;
         resp_valid     <= valid_n;
         resp_rdata     <= rdata_n;
         resp_error     <= error_n;
         memRead        <= rd_n;
         memWrite       <= wr_n;
         byteOperations <= bo_n;
         address        <= addr_n;
         write_data     <= wdata_n;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-array reference model.
module tb_load_store_unit;

   localparam int unsigned AW        = 18;
   localparam int unsigned MEM_BYTES = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_error;
   logic [31:0]   resp_rdata;
   logic          memRead, memWrite, byteOperations;
   logic [AW-1:0] address;
   logic [31:0]   write_data, read_data;

   bit [7:0] mem     [MEM_BYTES];
   bit [7:0] ref_mem [MEM_BYTES];
   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_ADDR_W(AW), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .memRead(memRead), .memWrite(memWrite),
      .byteOperations(byteOperations), .address(address),
      .write_data(write_data), .read_data(read_data)
   );

   // Memory: little-endian bytes, word mode indexed by word number
   always_comb begin
      if (byteOperations) read_data = {24'h0, mem[address]};
      else read_data = {mem[{address[AW-3:0], 2'b11}], mem[{address[AW-3:0], 2'b10}],
                        mem[{address[AW-3:0], 2'b01}], mem[{address[AW-3:0], 2'b00}]};
   end

   always @(posedge clk) begin
      if (memWrite) begin
         if (byteOperations) mem[address] <= write_data[7:0];
         else begin
            mem[{address[AW-3:0], 2'b00}] <= write_data[7:0];
            mem[{address[AW-3:0], 2'b01}] <= write_data[15:8];
            mem[{address[AW-3:0], 2'b10}] <= write_data[23:16];
            mem[{address[AW-3:0], 2'b11}] <= write_data[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference: expected result, latency and access count; stores update ref_mem
   task automatic model(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] er, output bit ee,
                        output int elat, output int nacc);
      int i;
      logic [7:0]  b;
      logic [15:0] h;
      logic signed [31:0] s;
      ee = (a >= 32'h0004_0000) || (sz == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0)
           || (sz == 2'd1 && a[0]);
      er = 32'h0;
      i  = int'(a[AW-1:0]);
      if (ee) begin
         elat = 1;
         nacc = 0;
         return;
      end
      nacc = (sz == 2'd1) ? 2 : 1;
      elat = nacc + 1;
      if (w) begin
         case (sz)
            2'd0: ref_mem[i] = wd[7:0];
            2'd1: begin ref_mem[i] = wd[7:0]; ref_mem[i+1] = wd[15:8]; end
            default: for (int j = 0; j < 4; j++) ref_mem[i+j] = wd[8*j +: 8];
         endcase
      end else begin
         case (sz)
            2'd0: begin
               b = ref_mem[i];
               if (uns) er = {24'h0, b};
               else begin s = $signed(b); er = s; end
            end
            2'd1: begin
               h = {ref_mem[i+1], ref_mem[i]};
               if (uns) er = {16'h0, h};
               else begin s = $signed(h); er = s; end
            end
            default: er = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
         endcase
      end
   endtask

   // One request from an idle negedge through its response
   task automatic xact(input string tag, input bit w, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] er, ewd0;
      bit ee;
      int elat, nacc, lat, nrd, nwr, n;
      logic [AW-1:0] sa[2];
      logic [31:0]   sd[2];
      logic          sb[2];
      sa[0] = '0; sa[1] = '0; sd[0] = '0; sd[1] = '0; sb[0] = 1'b0; sb[1] = 1'b0;
      model(w, sz, uns, a, wd, er, ee, elat, nacc);
      check({tag, ":ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; nrd = 0; nwr = 0;
      while (!resp_valid && lat < 8) begin
         if (memRead || memWrite) begin
            n = nrd + nwr;
            if (n < 2) begin sa[n] = address; sd[n] = write_data; sb[n] = byteOperations; end
            nrd += int'(memRead);
            nwr += int'(memWrite);
         end
         @(negedge clk);
         lat++;
      end
      check({tag, ":latency"}, 32'(lat), 32'(elat));
      check({tag, ":error"}, 32'(resp_error), 32'(ee));
      check({tag, ":rdata"}, resp_rdata, er);
      check({tag, ":busy"}, 32'(req_ready), 32'd0);
      check({tag, ":reads"}, 32'(nrd), (!ee && !w) ? 32'(nacc) : 32'd0);
      check({tag, ":writes"}, 32'(nwr), (!ee && w) ? 32'(nacc) : 32'd0);
      if (!ee) begin
         check({tag, ":addr0"}, 32'(sa[0]), (sz == 2'd2) ? (a >> 2) : 32'(a[AW-1:0]));
         check({tag, ":byteop"}, 32'(sb[0]), (sz == 2'd2) ? 32'd0 : 32'd1);
         ewd0 = (sz == 2'd2) ? wd : {24'h0, wd[7:0]};
         if (w) check({tag, ":wdata0"}, sd[0], ewd0);
         if (sz == 2'd1) begin
            check({tag, ":addr1"}, 32'(sa[1]), 32'(a[AW-1:0]) + 32'd1);
            if (w) check({tag, ":wdata1"}, sd[1], {24'h0, wd[15:8]});
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] er, a, wd;
      logic [31:0] eq[$];
      logic [1:0]  sz;
      bit ee, w, uns;
      int elat, nacc, k, got, last, strobes, spurious, r;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst:ready", 32'(req_ready), 32'd1);
      check("rst:resp_valid", 32'(resp_valid), 32'd0);
      check("rst:resp_error", 32'(resp_error), 32'd0);
      check("rst:resp_rdata", resp_rdata, 32'd0);
      check("rst:strobes", 32'({memRead, memWrite, byteOperations}), 32'd0);
      check("rst:address", 32'(address), 32'd0);
      check("rst:write_data", write_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      xact("sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      xact("lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      xact("sw80", 1'b1, 2'd2, 1'b0, 32'h100, 32'h8000_0000);
      xact("lb", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
      xact("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
      xact("sh1234", 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234);
      xact("lh1234", 1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
      xact("sh8001", 1'b1, 2'd1, 1'b0, 32'h202, 32'h8001);
      xact("lh8001", 1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
      xact("lhu8001", 1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
      xact("err_lw", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
      xact("err_lh", 1'b0, 2'd1, 1'b0, 32'h201, 32'h0);
      xact("err_range", 1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'h0);
      xact("err_size", 1'b1, 2'd3, 1'b0, 32'h100, 32'h55);

      // Reset lands on the edge that would start the high-byte access
      xact("sh_pre", 1'b1, 2'd1, 1'b0, 32'h300, 32'h5566);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 32'h300; req_wdata = 32'hABCD;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid:acc0_write", 32'(memWrite), 32'd1);
      check("rstmid:acc0_addr", 32'(address), 32'h300);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid:strobes", 32'({memRead, memWrite}), 32'd0);
      check("rstmid:ready", 32'(req_ready), 32'd1);
      check("rstmid:resp_valid", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      ref_mem[32'h300] = 8'hCD;
      spurious = 0;
      repeat (4) begin
         @(negedge clk);
         spurious += int'(resp_valid) + int'(memWrite) + int'(memRead);
      end
      check("rstmid:no_activity", 32'(spurious), 32'd0);
      check("rstmid:low_byte", 32'(mem[32'h300]), 32'hCD);
      check("rstmid:high_byte", 32'(mem[32'h301]), 32'h55);
      xact("rstmid:lhu", 1'b0, 2'd1, 1'b1, 32'h300, 32'h0);

      // Back-to-back byte/word requests with req_valid held high
      k = 0; got = 0; last = -1; strobes = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         if (memRead || memWrite) strobes++;
         if (resp_valid) begin
            if (eq.size() > 0) check("b2b:rdata", resp_rdata, eq.pop_front());
            check("b2b:ready_low", 32'(req_ready), 32'd0);
            if (last >= 0) check("b2b:spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            got++;
         end
         if (req_ready) begin
            if (k < 8) begin
               w  = 1'($urandom_range(0, 1));
               sz = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
               a  = 32'($urandom_range(0, 255)) * 32'd4;
               if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
               wd  = $urandom;
               uns = 1'($urandom_range(0, 1));
               model(w, sz, uns, a, wd, er, ee, elat, nacc);
               eq.push_back(er);
               req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
               req_addr = a; req_wdata = wd;
               k++;
            end else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check("b2b:responses", 32'(got), 32'd8);
      check("b2b:strobes", 32'(strobes), 32'd8);
      @(negedge clk);

      // Random mix including misaligned, out-of-range and illegal-size requests
      repeat (80) begin
         w   = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         r   = int'($urandom_range(0, 15));
         sz  = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
         a   = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd2) a[1:0] = 2'b00;
            if (sz == 2'd1) a[0] = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(18, 31));
         wd = $urandom;
         xact("rnd", w, sz, uns, a, wd);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
